split_accumulator: RTL

Sequencer and accumulator for one oblique decision-tree node. It sits directly downstream of the signed multiplier (`y = a*x`): it steps the feature index, enables the multiplier, sums the N signed products into a dot product, and compares the sum against the node threshold. The resulting branch decision is offered to the tree walker over a valid/ready handshake.

---
 rtl/dtree_pkg.sv | 36 +++
 rtl/split_accumulator_if.sv | 33 +++
 rtl/split_datapath.sv | 46 ++++
 rtl/split_accumulator.sv | 92 +++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Purpose: shared types and width rules for the oblique decision-tree node blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dtree_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CMP   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Bits needed to index v items; v >= 2 is assumed by every user.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Signed product width out of the multiplier.
  function automatic int width_p(input int wx, input int wa);
    return wx + wa + 1;
  endfunction

  // Accumulator width: product width plus growth for n terms.
  function automatic int width_acc(input int wp, input int n);
    return wp + clog2(n);
  endfunction

endpackage

// File: rtl/split_accumulator_if.sv
// Purpose: bundle of the node sequencer's multiplier-side and walker-side signals.
// Latency: n/a (wiring only).
// Backpressure: result_valid/result_ready handshake toward the tree walker.
interface split_accumulator_if #(
  parameter int WIDTH_X    = 10,
  parameter int WIDTH_A    = 4,
  parameter int N_FEATURES = 8
);
  localparam int WIDTH_P   = dtree_pkg::width_p(WIDTH_X, WIDTH_A);
  localparam int WIDTH_ACC = dtree_pkg::width_acc(WIDTH_P, N_FEATURES);
  localparam int IDX_W     = dtree_pkg::clog2(N_FEATURES);

  logic                        start;
  logic signed [WIDTH_ACC-1:0] threshold;
  logic signed [WIDTH_P-1:0]   p;
  logic                        mult_en;
  logic [IDX_W-1:0]            feat_idx;
  logic                        busy;
  logic                        result_valid;
  logic                        result_ready;
  logic                        decision;
  logic signed [WIDTH_ACC-1:0] acc;

  modport master (
    output start, threshold, p, result_ready,
    input  mult_en, feat_idx, busy, result_valid, decision, acc
  );

  modport slave (
    input  start, threshold, p, result_ready,
    output mult_en, feat_idx, busy, result_valid, decision, acc
  );
endinterface

// File: rtl/split_datapath.sv
// Purpose: accumulator, latched threshold and signed strict comparator for one node.
// Latency: one edge per strobe (clear / accumulate / compare).
// Backpressure: none; strobes come from the sequencer, which owns all flow control.
module split_datapath #(
  parameter int WIDTH_P   = 15,
  parameter int WIDTH_ACC = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        accum,
  input  logic                        cmp,
  input  logic signed [WIDTH_ACC-1:0] threshold,
  input  logic signed [WIDTH_P-1:0]   p,
  output logic signed [WIDTH_ACC-1:0] acc,
  output logic                        decision
);
  logic signed [WIDTH_ACC-1:0] acc_q;
  logic signed [WIDTH_ACC-1:0] thr_q;
  logic signed [WIDTH_ACC-1:0] p_ext;
  logic                        dec_q;

  assign p_ext = {{(WIDTH_ACC - WIDTH_P){p[WIDTH_P-1]}}, p};

  // Clear/latch on start, sum products while accumulating (wrapping), register the decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      thr_q <= '0;
      dec_q <= 1'b0;
    end else begin
      if (clear) begin
        acc_q <= '0;
        thr_q <= threshold;
      end else if (accum) begin
        acc_q <= acc_q + p_ext;
      end
      if (cmp) begin
        dec_q <= (acc_q > thr_q);
      end
    end
  end

  assign acc      = acc_q;
  assign decision = dec_q;
endmodule

// File: rtl/split_accumulator.sv
// Purpose: sequences N products from the multiplier into a dot product and compares to threshold.
// Latency: N_FEATURES+1 edges from accepted start to result_valid.
// Backpressure: result held until result_ready; start ignored while busy.
module split_accumulator #(
  parameter int WIDTH_X    = 10,
  parameter int WIDTH_A    = 4,
  parameter int N_FEATURES = 8
) (
  input logic               clk,
  input logic               reset,
  split_accumulator_if.slave bus
);
  import dtree_pkg::*;

  localparam int WIDTH_P   = width_p(WIDTH_X, WIDTH_A);
  localparam int WIDTH_ACC = width_acc(WIDTH_P, N_FEATURES);
  localparam int IDX_W     = clog2(N_FEATURES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEATURES - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             clear, accum, cmp;

  // State and feature index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state, index stepping and datapath strobes.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clear     = 1'b0;
    accum     = 1'b0;
    cmp       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          clear     = 1'b1;
          idx_nxt   = '0;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        accum = 1'b1;
        if (idx == LAST_IDX) begin
          idx_nxt   = '0;
          state_nxt = CMP;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      CMP: begin
        cmp       = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.result_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight off registered state, so the multiplier sees no glitches.
  assign bus.mult_en      = (state == ACCUM);
  assign bus.feat_idx     = idx;
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == HOLD);

  split_datapath #(
    .WIDTH_P  (WIDTH_P),
    .WIDTH_ACC(WIDTH_ACC)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .accum    (accum),
    .cmp      (cmp),
    .threshold(bus.threshold),
    .p        (bus.p),
    .acc      (bus.acc),
    .decision (bus.decision)
  );
endmodule
